// File: rtl/ptna_pkg.sv
// Shared types for the ternary-neuron popcount accumulator.
// PTNA_SAT_EN selects a saturating accumulator in ptna_acc_add.
package ptna_pkg;

    typedef enum logic [1:0] {
        ACT_ZERO = 2'b00,
        ACT_POS  = 2'b01,
        ACT_NEG  = 2'b11
    } act_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/ptna_acc_add.sv
// Signed accumulate step: o_sum = i_base + (pos - neg).
// With PTNA_SAT_EN defined the result clamps to the ACC_W range, otherwise it wraps.
module ptna_acc_add #(
    parameter int CNT_W = 5,
    parameter int ACC_W = 10
) (
    input  logic signed [ACC_W-1:0] i_base,
    input  logic        [CNT_W-1:0] i_pos,
    input  logic        [CNT_W-1:0] i_neg,
    output logic signed [ACC_W-1:0] o_sum
);

`ifdef PTNA_SAT_EN
    // Wide enough that base + delta can never overflow before clamping.
    localparam int EXT_W = ACC_W + CNT_W + 2;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (ACC_W-1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(64'sd1 <<< (ACC_W-1)));

    logic signed [EXT_W-1:0] w_base_ext;
    logic signed [EXT_W-1:0] w_pos_ext;
    logic signed [EXT_W-1:0] w_neg_ext;
    logic signed [EXT_W-1:0] w_ext;

    assign w_base_ext = {{(EXT_W-ACC_W){i_base[ACC_W-1]}}, i_base};
    assign w_pos_ext  = {{(EXT_W-CNT_W){1'b0}}, i_pos};
    assign w_neg_ext  = {{(EXT_W-CNT_W){1'b0}}, i_neg};
    assign w_ext      = w_base_ext + w_pos_ext - w_neg_ext;

    always_comb begin
        o_sum = w_ext[ACC_W-1:0];
        if (w_ext > SAT_MAX) begin
            o_sum = SAT_MAX[ACC_W-1:0];
        end else if (w_ext < SAT_MIN) begin
            o_sum = SAT_MIN[ACC_W-1:0];
        end
    end
`else
    logic signed [ACC_W-1:0] w_delta;

    assign w_delta = ACC_W'(i_pos) - ACC_W'(i_neg);
    assign o_sum   = i_base + w_delta;
`endif

endmodule

// File: rtl/popcount_ternary_neuron_acc.sv
// Frame accumulator of (pos - neg) popcounts with a two-threshold ternary activation.
// PTNA_SAT_EN selects saturating accumulation (see ptna_acc_add).
module popcount_ternary_neuron_acc
    import ptna_pkg::*;
#(
    parameter int CNT_W     = 5,
    parameter int ACC_W     = 10,
    parameter int MAX_BEATS = 16,
    parameter int BEAT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic        [CNT_W-1:0] pos_cnt,
    input  logic        [CNT_W-1:0] neg_cnt,
    input  logic                    in_last,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [1:0]       out_act,
    output logic                    out_trunc,
    output state_t                  dbg_state
);

    // Handshakes: a beat moves on in_valid & in_ready, an activation on out_valid & out_ready;
    // out_valid, once high, holds with out_act/out_trunc stable until out_ready.
    state_t                  r_state;
    state_t                  w_next;
    logic signed [ACC_W-1:0] r_acc;
    logic        [BEAT_W-1:0] r_beat;
    logic signed [ACC_W-1:0] r_thr_hi;
    logic signed [ACC_W-1:0] r_thr_lo;
    act_t                    r_act;
    logic                    r_trunc;

    logic                    w_acc_en;
    logic                    w_at_max;
    logic                    w_close;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_thr_hi;
    logic signed [ACC_W-1:0] w_thr_lo;
    act_t                    w_act;

    ptna_acc_add #(.CNT_W(CNT_W), .ACC_W(ACC_W)) u_add (
        .i_base (w_base),
        .i_pos  (pos_cnt),
        .i_neg  (neg_cnt),
        .o_sum  (w_sum)
    );

    // The first beat of a frame starts from zero and sees the live thresholds.
    assign w_base   = (r_state == IDLE) ? '0 : r_acc;
    assign w_thr_hi = (r_state == IDLE) ? thr_hi : r_thr_hi;
    assign w_thr_lo = (r_state == IDLE) ? thr_lo : r_thr_lo;
    assign w_acc_en = in_valid && (r_state != OUT);
    assign w_at_max = (r_state == IDLE) ? (MAX_BEATS == 1)
                                        : (r_beat == BEAT_W'(MAX_BEATS - 1));
    assign w_close  = w_acc_en && (in_last || w_at_max);

    always_comb begin
        w_act = ACT_ZERO;
        if (w_sum >= w_thr_hi) begin
            w_act = ACT_POS;
        end else if (w_sum <= w_thr_lo) begin
            w_act = ACT_NEG;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc_en) w_next = w_close ? OUT : ACC;
            ACC:     if (w_close) w_next = OUT;
            OUT:     if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_beat   <= '0;
            r_thr_hi <= '0;
            r_thr_lo <= '0;
            r_act    <= ACT_ZERO;
            r_trunc  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc_en) begin
                r_acc  <= w_sum;
                r_beat <= (r_state == IDLE) ? BEAT_W'(1) : r_beat + BEAT_W'(1);
                if (r_state == IDLE) begin
                    r_thr_hi <= thr_hi;
                    r_thr_lo <= thr_lo;
                end
                if (w_close) begin
                    r_act   <= w_act;
                    r_trunc <= !in_last;
                end
            end
            if (r_state == OUT && out_ready) begin
                r_acc   <= '0;
                r_beat  <= '0;
                r_act   <= ACT_ZERO;
                r_trunc <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state != OUT);
    assign out_valid = (r_state == OUT);
    assign out_act   = r_act;
    assign out_trunc = r_trunc;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_popcount_ternary_neuron_acc.sv
// Directed bench for popcount_ternary_neuron_acc; a second instance with ACC_W=6
// exercises wrap or saturation depending on PTNA_SAT_EN.
module tb_popcount_ternary_neuron_acc;
    import ptna_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        pos_cnt = '0;
    logic [4:0]        neg_cnt = '0;
    logic              in_last = 1'b0;
    logic signed [9:0] thr_hi = '0;
    logic signed [9:0] thr_lo = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        out_act;
    logic              out_trunc;
    state_t            dbg_state;

    logic              in_valid6 = 1'b0;
    logic              in_ready6;
    logic [4:0]        pos6 = '0;
    logic [4:0]        neg6 = '0;
    logic              in_last6 = 1'b0;
    logic signed [5:0] thr_hi6 = '0;
    logic signed [5:0] thr_lo6 = '0;
    logic              out_valid6;
    logic              out_ready6 = 1'b0;
    logic [1:0]        out_act6;
    logic              out_trunc6;
    state_t            dbg_state6;

    int n_tests = 0;
    int n_fail  = 0;

    popcount_ternary_neuron_acc u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pos_cnt(pos_cnt), .neg_cnt(neg_cnt), .in_last(in_last),
        .thr_hi(thr_hi), .thr_lo(thr_lo), .out_valid(out_valid),
        .out_ready(out_ready), .out_act(out_act), .out_trunc(out_trunc),
        .dbg_state(dbg_state)
    );

    popcount_ternary_neuron_acc #(.ACC_W(6)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6),
        .pos_cnt(pos6), .neg_cnt(neg6), .in_last(in_last6),
        .thr_hi(thr_hi6), .thr_lo(thr_lo6), .out_valid(out_valid6),
        .out_ready(out_ready6), .out_act(out_act6), .out_trunc(out_trunc6),
        .dbg_state(dbg_state6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One beat presented on a falling edge and accepted on the next rising edge.
    task automatic beat(input int p, input int n, input logic last, input int hi, input int lo);
        @(negedge clk);
        pos_cnt  = 5'(p);
        neg_cnt  = 5'(n);
        in_last  = last;
        thr_hi   = 10'(hi);
        thr_lo   = 10'(lo);
        in_valid = 1'b1;
        check("beat_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] act, input logic trunc);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_act"},   32'(out_act),   32'(act));
        check({tag, "_trunc"}, 32'(out_trunc), 32'(trunc));
    endtask

    task automatic take_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_state"}, 32'(dbg_state), 32'(IDLE));
        check({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_act",   32'(out_act),   32'd0);
        check("rst_out_trunc", 32'(out_trunc), 32'd0);
        check("rst_state",     32'(dbg_state), 32'(IDLE));
        rst = 1'b0;

        // Single beat 20-3=17 >= 10
        beat(20, 3, 1'b1, 10, -10);
        expect_out("t1", 2'b01, 1'b0);
        take_out("t1");

        // Three beats, sum -17 <= -5
        beat(5, 9, 1'b0, 5, -5);
        check("t2_mid_valid", 32'(out_valid), 32'd0);
        beat(2, 8, 1'b0, 0, 0);
        beat(0, 7, 1'b1, 0, 0);
        expect_out("t2", 2'b11, 1'b0);
        take_out("t2");

        // Sixteen zero-delta beats, never last: force-closed
        for (int i = 0; i < 16; i++) begin
            beat(1, 1, 1'b0, 5, -5);
            if (i == 14) check("t3_open_after_15", 32'(out_valid), 32'd0);
        end
        expect_out("t3", 2'b00, 1'b1);

        // Back-pressure: output holds, no beat accepted
        @(negedge clk);
        pos_cnt  = 5'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(out_valid), 32'd1);
            check("t4_hold_act",   32'(out_act),   32'd0);
            check("t4_hold_trunc", 32'(out_trunc), 32'd1);
            check("t4_hold_ready", 32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        take_out("t4");
        check("t4_trunc_cleared", 32'(out_trunc), 32'd0);

        // Reset mid-frame after +20
        beat(10, 0, 1'b0, 100, -100);
        beat(10, 0, 1'b0, 100, -100);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_state", 32'(dbg_state), 32'(IDLE));
        check("t5_rst_ready", 32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(0, 4, 1'b1, 10, -3);
        expect_out("t5", 2'b11, 1'b0);
        take_out("t5");

        // Sum equal to thr_hi, equal to thr_lo, and overlapping thresholds
        beat(5, 0, 1'b1, 5, -5);
        expect_out("t6_eq_hi", 2'b01, 1'b0);
        take_out("t6a");
        beat(0, 5, 1'b1, 5, -5);
        expect_out("t6_eq_lo", 2'b11, 1'b0);
        take_out("t6b");
        beat(0, 0, 1'b1, 0, 5);
        expect_out("t6_prio", 2'b01, 1'b0);
        take_out("t6c");

        // Thresholds come from the first beat only
        beat(5, 0, 1'b0, 3, -3);
        beat(0, 0, 1'b1, 100, -100);
        expect_out("t7_thr_latch", 2'b01, 1'b0);
        take_out("t7");

        // ACC_W=6: 4 x 31 either clamps at 31 or wraps to -4
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pos6      = 5'd31;
            neg6      = 5'd0;
            thr_hi6   = 6'sd31;
            thr_lo6   = -6'sd10;
            in_last6  = (i == 3);
            in_valid6 = 1'b1;
            @(posedge clk);
            #1;
            in_valid6 = 1'b0;
            in_last6  = 1'b0;
        end
        check("t8_valid", 32'(out_valid6), 32'd1);
`ifdef PTNA_SAT_EN
        check("t8_act_sat", 32'(out_act6), 32'h1);
`else
        check("t8_act_wrap", 32'(out_act6), 32'h0);
`endif
        check("t8_trunc", 32'(out_trunc6), 32'd0);
        @(negedge clk);
        out_ready6 = 1'b1;
        @(posedge clk);
        #1;
        out_ready6 = 1'b0;
        check("t8_idle", 32'(dbg_state6), 32'(IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
